// File: rtl/bus_demux12.sv
`default_nettype none
// ============================================================================
// bus_demux12 : routes one CPU data-bus request to RAM (t0) or peripherals (t1)
//               by addr[SEL_BIT], waits for that target's ack, returns rdata.
//               Optional macro DEMUX_TIMEOUT_EN adds a BUSY timeout error reply.
// Revision    : 1.0  initial release
// ============================================================================
module bus_demux12 #(
  parameter int SEL_BIT = 12
`ifdef DEMUX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        t0_req_o,
  output logic        t1_req_o,
  output logic        tx_we_o,
  output logic [31:0] tx_addr_o,
  output logic [31:0] tx_wdata_o,
  input  logic        t0_ack_i,
  input  logic        t1_ack_i,
  input  logic [31:0] t0_rdata_i,
  input  logic [31:0] t1_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic        t0_req_q, t0_req_d;
  logic        t1_req_q, t1_req_d;
  logic        tx_we_q, tx_we_d;
  logic [31:0] tx_addr_q, tx_addr_d;
  logic [31:0] tx_wdata_q, tx_wdata_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;

  logic        sel_ack;
  logic [31:0] sel_rdata;

  // Only the target chosen at accept time may complete the transaction.
  assign sel_ack   = sel_q ? t1_ack_i   : t0_ack_i;
  assign sel_rdata = sel_q ? t1_rdata_i : t0_rdata_i;

`ifdef DEMUX_TIMEOUT_EN
  localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    t0_req_d   = t0_req_q;
    t1_req_d   = t1_req_q;
    tx_we_d    = tx_we_q;
    tx_addr_d  = tx_addr_q;
    tx_wdata_d = tx_wdata_q;
    ack_d      = 1'b0;
    rdata_d    = 32'h0;
`ifdef DEMUX_TIMEOUT_EN
    err_d      = 1'b0;
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_i) begin
          tx_we_d    = we_i;
          tx_addr_d  = addr_i;
          tx_wdata_d = wdata_i;
          sel_d      = addr_i[SEL_BIT];
          t0_req_d   = ~addr_i[SEL_BIT];
          t1_req_d   = addr_i[SEL_BIT];
          state_d    = BUSY;
`ifdef DEMUX_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      BUSY: begin
        // A real ack takes priority over a timeout in the same cycle.
        if (sel_ack) begin
          t0_req_d = 1'b0;
          t1_req_d = 1'b0;
          ack_d    = 1'b1;
          rdata_d  = tx_we_q ? 32'h0 : sel_rdata;
          state_d  = RESP;
        end
`ifdef DEMUX_TIMEOUT_EN
        else if (cnt_q == c_cnt_last) begin
          t0_req_d = 1'b0;
          t1_req_d = 1'b0;
          ack_d    = 1'b1;
          rdata_d  = 32'hDEAD_BEEF;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        // The response pulse is on the outputs now; req_i is deliberately not looked at.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      t0_req_q   <= 1'b0;
      t1_req_q   <= 1'b0;
      tx_we_q    <= 1'b0;
      tx_addr_q  <= 32'h0;
      tx_wdata_q <= 32'h0;
      ack_q      <= 1'b0;
      rdata_q    <= 32'h0;
`ifdef DEMUX_TIMEOUT_EN
      err_q      <= 1'b0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      t0_req_q   <= t0_req_d;
      t1_req_q   <= t1_req_d;
      tx_we_q    <= tx_we_d;
      tx_addr_q  <= tx_addr_d;
      tx_wdata_q <= tx_wdata_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
`ifdef DEMUX_TIMEOUT_EN
      err_q      <= err_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign ack_o      = ack_q;
  assign rdata_o    = rdata_q;
  assign t0_req_o   = t0_req_q;
  assign t1_req_o   = t1_req_q;
  assign tx_we_o    = tx_we_q;
  assign tx_addr_o  = tx_addr_q;
  assign tx_wdata_o = tx_wdata_q;
`ifdef DEMUX_TIMEOUT_EN
  assign err_o      = err_q;
`else
  assign err_o      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_demux12.sv
`default_nettype none
// ============================================================================
// tb_bus_demux12 : randomized bench for bus_demux12 with a transaction-level
//                  scoreboard; timeout cases run when DEMUX_TIMEOUT_EN is defined.
// Revision       : 1.0  initial release
// ============================================================================
module tb_bus_demux12;

  localparam int TB_TIMEOUT = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic        ack_o, err_o;
  logic [31:0] rdata_o;
  logic        t0_req_o, t1_req_o, tx_we_o;
  logic [31:0] tx_addr_o, tx_wdata_o;
  logic        t0_ack_i = 1'b0, t1_ack_i = 1'b0;
  logic [31:0] t0_rdata_i = 32'h0, t1_rdata_i = 32'h0;

  always #5 clk_i = ~clk_i;

  bus_demux12 dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ack_o(ack_o), .rdata_o(rdata_o),
    .err_o(err_o), .t0_req_o(t0_req_o), .t1_req_o(t1_req_o), .tx_we_o(tx_we_o),
    .tx_addr_o(tx_addr_o), .tx_wdata_o(tx_wdata_o), .t0_ack_i(t0_ack_i),
    .t1_ack_i(t1_ack_i), .t0_rdata_i(t0_rdata_i), .t1_rdata_i(t1_rdata_i)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0;
  int          n_started = 0, n_done = 0, n_acks = 0;
  int          t0_rises = 0, t1_rises = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  // Transaction currently owned by the CPU side, and the one before it.
  logic        cur_we = 1'b0, prev_we = 1'b0;
  logic [31:0] cur_addr = 32'h0, prev_addr = 32'h0;
  logic [31:0] cur_wdata = 32'h0, prev_wdata = 32'h0;
  logic        accepted = 1'b0;

  int          rsp_delay = 0;
  logic [31:0] rsp_data = 32'h0;
  logic        rsp_stray = 1'b0;
  logic        rsp_mute = 1'b0;
  int          wait_cnt = -1;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not as required (cycle %0d)", name, cyc);
  endtask

  // Target side: the requested target acks after rsp_delay cycles; strays hit the other one.
  always @(negedge clk_i) begin
    t0_ack_i   = 1'b0;
    t1_ack_i   = 1'b0;
    t0_rdata_i = $urandom;
    t1_rdata_i = $urandom;
    if (t0_req_o || t1_req_o) begin
      if (wait_cnt == -1) begin
        wait_cnt = rsp_delay;
`ifdef DEMUX_TIMEOUT_EN
        if (rsp_mute) exp_q.push_back('{32'hDEAD_BEEF, 1'b1, cyc + TB_TIMEOUT});
`endif
      end
      if (wait_cnt == 0 && !rsp_mute) begin
        if (t1_req_o) begin t1_ack_i = 1'b1; t1_rdata_i = rsp_data; end
        else          begin t0_ack_i = 1'b1; t0_rdata_i = rsp_data; end
        exp_q.push_back('{cur_we ? 32'h0 : rsp_data, 1'b0, cyc + 1});
        wait_cnt = -2;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end
      if (rsp_stray) begin
        if (t1_req_o) t0_ack_i = 1'b1;
        else          t1_ack_i = 1'b1;
      end
    end else begin
      wait_cnt = -1;
      if (rsp_stray && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1) t0_ack_i = 1'b1;
        else                           t1_ack_i = 1'b1;
      end
    end
  end

  // Scoreboard: checks every cycle, a few ns after the active edge.
  logic prev_t0 = 1'b0, prev_t1 = 1'b0;
  always @(posedge clk_i) begin
    exp_t e;
    #3;
    if (rst_i) begin
      chk("reset_ctrl", {ack_o, err_o, t0_req_o, t1_req_o, tx_we_o}, 0);
      chk("reset_rdata", rdata_o, 0);
      chk("reset_tx_addr", tx_addr_o, 0);
      chk("reset_tx_wdata", tx_wdata_o, 0);
      exp_q.delete();
    end else begin
      chk("one_target_req", t0_req_o & t1_req_o, 0);
      if (t0_req_o || t1_req_o) begin
        chk("req_target", {t1_req_o, t0_req_o}, cur_addr[12] ? 2'b10 : 2'b01);
        chk("tx_we", tx_we_o, cur_we);
        chk("tx_addr", tx_addr_o, cur_addr);
        chk("tx_wdata", tx_wdata_o, cur_wdata);
      end else if (accepted) begin
        chk("tx_hold_addr", tx_addr_o, cur_addr);
        chk("tx_hold_wdata", {tx_we_o, tx_wdata_o}, {cur_we, cur_wdata});
      end else begin
        chk("tx_hold_prev", {tx_we_o, tx_addr_o, tx_wdata_o}, {prev_we, prev_addr, prev_wdata});
      end
      if (ack_o) begin
        n_acks++;
        last_rdata = rdata_o;
        last_err   = err_o;
        if (exp_q.size() == 0) begin
          fail("unexpected_ack");
        end else begin
          e = exp_q.pop_front();
          chk("ack_cycle", cyc, e.cyc);
          chk("ack_rdata", rdata_o, e.rdata);
          chk("ack_err", err_o, e.err);
        end
      end else begin
        chk("quiet_rdata_err", {rdata_o, err_o}, 0);
        if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
          fail("missing_ack");
          void'(exp_q.pop_front());
        end
      end
    end
    if (t0_req_o && !prev_t0) t0_rises++;
    if (t1_req_o && !prev_t1) t1_rises++;
    prev_t0 = t0_req_o;
    prev_t1 = t1_req_o;
  end

  // CPU side: one request held until ack_o (optionally one cycle longer).
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] data, input int delay, input logic stray,
                     input logic hold, input logic mute);
    int   exp_lat;
    logic got;
    rsp_data   = data;
    rsp_delay  = delay;
    rsp_stray  = stray;
    rsp_mute   = mute;
    prev_we    = cur_we;
    prev_addr  = cur_addr;
    prev_wdata = cur_wdata;
    cur_we     = we;
    cur_addr   = addr;
    cur_wdata  = wdata;
    accepted   = 1'b0;
    // A request raised while the previous response is showing waits one extra cycle.
    exp_lat    = ack_o ? 2 : 1;
    req_i      = 1'b1;
    we_i       = we;
    addr_i     = addr;
    wdata_i    = wdata;
    n_started++;
    got = 1'b0;
    for (int lat = 1; lat <= 40 && !got; lat++) begin
      @(negedge clk_i);
      if (!accepted && (t0_req_o || t1_req_o)) begin
        accepted = 1'b1;
        chk("req_latency", lat, exp_lat);
      end
      if (ack_o) got = 1'b1;
    end
    if (!got) fail("ack_wait_expired");
    n_done++;
    if (hold) @(negedge clk_i);
    req_i     = 1'b0;
    we_i      = $urandom;
    addr_i    = $urandom;
    wdata_i   = $urandom;
    rsp_stray = 1'b0;
    rsp_mute  = 1'b0;
  endtask

  initial begin
    int mark;
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    txn(1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 2, 1'b0, 1'b0, 1'b0);
    chk("read_t0_rdata", last_rdata, 32'h1234_5678);
    chk("read_t0_err", last_err, 0);
    @(negedge clk_i);

    mark = t0_rises;
    txn(1'b1, 32'h0000_1004, 32'hCAFE_0001, 32'h7777_7777, 1, 1'b0, 1'b0, 1'b0);
    chk("write_t1_rdata", last_rdata, 0);
    chk("write_t1_no_t0", t0_rises - mark, 0);
    @(negedge clk_i);

    txn(1'b0, 32'h0000_0080, 32'h0, 32'hA5A5_0003, 4, 1'b1, 1'b0, 1'b0);
    chk("stray_rdata", last_rdata, 32'hA5A5_0003);

    txn(1'b0, 32'h0000_1200, 32'h0, 32'h0000_1111, 0, 1'b0, 1'b1, 1'b0);
    txn(1'b0, 32'h0000_0300, 32'h0, 32'h0000_2222, 0, 1'b0, 1'b0, 1'b0);
    txn(1'b1, 32'h0000_1300, 32'h5555_AAAA, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    chk("b2b_reqs", t0_rises + t1_rises, n_started);

    // Reset in the middle of BUSY: abandoned, no response may follow.
    @(negedge clk_i);
    rsp_delay = 6; rsp_data = 32'h0; rsp_mute = 1'b0;
    prev_we = cur_we; prev_addr = cur_addr; prev_wdata = cur_wdata;
    cur_we = 1'b0; cur_addr = 32'h0000_1040; cur_wdata = 32'h0; accepted = 1'b0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_1040; wdata_i = 32'h0;
    n_started++;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1; req_i = 1'b0;
    cur_we = 1'b0; cur_addr = 32'h0; cur_wdata = 32'h0;
    prev_we = 1'b0; prev_addr = 32'h0; prev_wdata = 32'h0;
    @(negedge clk_i);
    rst_i = 1'b0;
    mark = n_acks;
    repeat (8) @(negedge clk_i);
    chk("no_ack_after_reset", n_acks - mark, 0);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      txn(1'($urandom_range(0, 1)), a, $urandom, $urandom, $urandom_range(0, 4),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef DEMUX_TIMEOUT_EN
    @(negedge clk_i);
    txn(1'b0, 32'h0000_1100, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b1);
    chk("timeout_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("timeout_err", last_err, 1);
    @(negedge clk_i);
    txn(1'b0, 32'h0000_0200, 32'h0, 32'h0BAD_F00D, TB_TIMEOUT - 1, 1'b0, 1'b0, 1'b0);
    chk("late_ack_rdata", last_rdata, 32'h0BAD_F00D);
    chk("late_ack_err", last_err, 0);
`endif

    repeat (4) @(negedge clk_i);
    chk("reqs_per_txn", t0_rises + t1_rises, n_started);
    chk("acks_per_txn", n_acks, n_done);
    chk("pending_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
